// File: rtl/bound_flasher_ctrl.sv
// Sequencing controller for the 16-lamp bound flasher: synchronises flick, runs the
// six-phase up/down lamp sequence with kickback, and drives a thermometer lamp bus.
module bound_flasher_ctrl #(
  parameter int TICK_DIV    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flick,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] led,
  output logic [2:0]  state_o,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    ON0_15  = 3'd1,
    OFF15_5 = 3'd2,
    ON5_10  = 3'd3,
    OFF10_0 = 3'd4,
    ON0_5   = 3'd5,
    OFF5_0  = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   flick_s;
  logic [2:0]             state_r, state_nxt_s, adv_s;
  logic [4:0]             cnt_r, cnt_nxt_s, cnt_inc_s, cnt_dec_s, step_s;
  logic [4:0]             bound_s, kick_val_s;
  logic [PW-1:0]          pre_r, pre_nxt_s;
  logic                   tick_s, dir_up_s, kick_s, legal_s;
  logic [15:0]            led_r;
  logic                   busy_r;

  function automatic logic [15:0] therm(input logic [4:0] c);
    if (c >= 5'd16) begin
      return 16'hFFFF;
    end else begin
      return (16'd1 << c) - 16'd1;
    end
  endfunction

  // Flick synchroniser; keeps running regardless of en and clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], flick};
    end
  end

  assign flick_s   = sync_r[SYNC_STAGES-1];
  assign tick_s    = en && (pre_r == PRE_LAST) && (state_r != INIT);
  assign cnt_inc_s = cnt_r + 5'd1;
  assign cnt_dec_s = cnt_r - 5'd1;
  assign step_s    = dir_up_s ? cnt_inc_s : cnt_dec_s;

  // Per-phase direction, exit bound, successor and kickback condition
  always_comb begin
    dir_up_s   = 1'b0;
    bound_s    = 5'd0;
    adv_s      = INIT;
    kick_s     = 1'b0;
    kick_val_s = 5'd0;
    legal_s    = 1'b1;
    case (state_r)
      INIT:    begin legal_s = 1'b1; end
      ON0_15:  begin dir_up_s = 1'b1; bound_s = 5'd16; adv_s = OFF15_5; end
      OFF15_5: begin
        bound_s    = 5'd5;
        adv_s      = ON5_10;
        kick_s     = flick_s && (cnt_dec_s == 5'd5);
        kick_val_s = 5'd16;
      end
      ON5_10:  begin dir_up_s = 1'b1; bound_s = 5'd10; adv_s = OFF10_0; end
      OFF10_0: begin
        bound_s    = 5'd0;
        adv_s      = ON0_5;
        kick_s     = flick_s && ((cnt_dec_s == 5'd5) || (cnt_dec_s == 5'd0));
        kick_val_s = 5'd10;
      end
      ON0_5:   begin dir_up_s = 1'b1; bound_s = 5'd5; adv_s = OFF5_0; end
      OFF5_0:  begin bound_s = 5'd0; adv_s = INIT; end
      default: begin legal_s = 1'b0; end
    endcase
  end

  // Next state/counter; clr and illegal codes collapse to INIT, kickback beats step and exit
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (clr || !legal_s) begin
      state_nxt_s = INIT;
      cnt_nxt_s   = 5'd0;
    end else if (state_r == INIT) begin
      if (flick_s && en) begin
        state_nxt_s = ON0_15;
        cnt_nxt_s   = 5'd0;
      end else begin
        state_nxt_s = INIT;
        cnt_nxt_s   = 5'd0;
      end
    end else if (tick_s) begin
      if (kick_s) begin
        cnt_nxt_s = kick_val_s;
      end else begin
        cnt_nxt_s = step_s;
        if (step_s == bound_s) begin
          state_nxt_s = adv_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Step-rate prescaler: parked at zero in INIT, frozen while en is low
  always_comb begin
    pre_nxt_s = pre_r;
    if (clr || !legal_s || (state_r == INIT) || tick_s) begin
      pre_nxt_s = '0;
    end else if (en) begin
      pre_nxt_s = pre_r + PW'(1);
    end else begin
      pre_nxt_s = pre_r;
    end
  end

  // Main registers; lamp bus and busy are registered from the next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT;
      cnt_r   <= 5'd0;
      pre_r   <= '0;
      led_r   <= 16'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pre_r   <= pre_nxt_s;
      led_r   <= therm(cnt_nxt_s);
      busy_r  <= (state_nxt_s != INIT);
    end
  end

  assign led     = led_r;
  assign busy    = busy_r;
  assign state_o = state_r;

endmodule
